// File: rtl/cmu_pkg.sv
// cmu_pkg
//   Shared constants for the clock management unit front end:
//   fixed divider ratios for the derived clock domains and the default
//   lock / settle times used by cmu_clkgen.
package cmu_pkg;

  // Divider ratios relative to the 100 MHz reference.
  localparam int DIV_RT     = 2;   // RT-core clock, 50 MHz
  localparam int DIV_PERIPH = 4;   // peripheral clock, 25 MHz
  localparam int DIV_DEBUG  = 10;  // debug clock, 10 MHz

  // Default settle times, in reference cycles.
  localparam int DEF_LOCK_CYCLES  = 64;
  localparam int DEF_STABLE_COUNT = 128;

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cmu_div_gen.sv
// cmu_div_gen
//   Divide-by-N clock and enable-strobe generator. The phase counter is
//   held at 0 until run is high, so every instance starts aligned in the
//   first run cycle, then counts 0..N-1 and wraps.
// Ports:
//   clk_in_100mhz  in   reference clock
//   rst            in   synchronous active-high clear of the phase counter
//   run            in   advance the phase counter (driven by locked)
//   clk_div        out  divided clock, high while phase < N/2
//   en_div         out  one-cycle strobe while phase == 0
module cmu_div_gen
  import cmu_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk_in_100mhz,
  input  logic rst,
  input  logic run,
  output logic clk_div,
  output logic en_div
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] phase_q;

  always_ff @(posedge clk_in_100mhz) begin
    if (rst || !run) begin
      phase_q <= '0;
    end else if (phase_q == PW'(N - 1)) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + PW'(1);
    end
  end

  // run comes from a register in the parent, so these stay free of any
  // input-to-output combinational path.
  assign clk_div = run && (phase_q < PW'(N / 2));
  assign en_div  = run && (phase_q == '0);

endmodule

// File: rtl/cmu_clkgen.sv
// cmu_clkgen
//   Behavioural clock-generation front end (MMCM + global buffer model)
//   running entirely in the 100 MHz reference domain.
//   Sequence after reset: lock counter saturates -> locked; the divided
//   clocks start phase-aligned; the stable counter saturates -> stable and
//   the downstream reset releases; the profiling counter then runs.
//   rst or pwrdwn at any edge restarts the whole sequence.
// Ports:
//   clk_in_100mhz  in   reference clock, sole clock of the block
//   rst            in   synchronous active-high reset
//   pwrdwn         in   synchronous power-down, same effect as rst
//   locked         out  lock counter reached LOCK_CYCLES
//   stable         out  stable counter reached STABLE_COUNT
//   rst_out        out  active-high downstream reset (= !stable)
//   clk_div2/4/10  out  divided clocks, 50% duty
//   en_div2/4/10   out  strobe on the first high cycle of each divided clock
//   cycle_count    out  free-running count of stable cycles, wraps
module cmu_clkgen
  import cmu_pkg::*;
#(
  parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
  parameter int STABLE_COUNT = DEF_STABLE_COUNT,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   clk_in_100mhz,
  input  logic                   rst,
  input  logic                   pwrdwn,
  output logic                   locked,
  output logic                   stable,
  output logic                   rst_out,
  output logic                   clk_div2,
  output logic                   clk_div4,
  output logic                   clk_div10,
  output logic                   en_div2,
  output logic                   en_div4,
  output logic                   en_div10,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  localparam int LW = cnt_width(LOCK_CYCLES);
  localparam int SW = cnt_width(STABLE_COUNT);

  logic                   clr;
  logic [LW-1:0]          lock_cnt_q;
  logic [SW-1:0]          stable_cnt_q;
  logic [COUNT_WIDTH-1:0] cycle_cnt_q;

  // Power-down is treated exactly like reset everywhere.
  assign clr = rst || pwrdwn;

  // Lock counter: saturates at LOCK_CYCLES.
  always_ff @(posedge clk_in_100mhz) begin
    if (clr) begin
      lock_cnt_q <= '0;
    end else if (lock_cnt_q != LW'(LOCK_CYCLES)) begin
      lock_cnt_q <= lock_cnt_q + LW'(1);
    end
  end

  assign locked = (lock_cnt_q == LW'(LOCK_CYCLES));

  // Stable counter: held at 0 until locked, then saturates at STABLE_COUNT.
  always_ff @(posedge clk_in_100mhz) begin
    if (clr || !locked) begin
      stable_cnt_q <= '0;
    end else if (stable_cnt_q != SW'(STABLE_COUNT)) begin
      stable_cnt_q <= stable_cnt_q + SW'(1);
    end
  end

  assign stable  = (stable_cnt_q == SW'(STABLE_COUNT));
  assign rst_out = !stable;

  // Profiling counter: advances on edges where stable was already high,
  // so it reads 0 in the first stable cycle. Wraps naturally.
  always_ff @(posedge clk_in_100mhz) begin
    if (clr) begin
      cycle_cnt_q <= '0;
    end else if (stable) begin
      cycle_cnt_q <= cycle_cnt_q + COUNT_WIDTH'(1);
    end
  end

  assign cycle_count = cycle_cnt_q;

  cmu_div_gen #(.N(DIV_RT)) u_div_rt (
    .clk_in_100mhz (clk_in_100mhz),
    .rst           (clr),
    .run           (locked),
    .clk_div       (clk_div2),
    .en_div        (en_div2)
  );

  cmu_div_gen #(.N(DIV_PERIPH)) u_div_periph (
    .clk_in_100mhz (clk_in_100mhz),
    .rst           (clr),
    .run           (locked),
    .clk_div       (clk_div4),
    .en_div        (en_div4)
  );

  cmu_div_gen #(.N(DIV_DEBUG)) u_div_debug (
    .clk_in_100mhz (clk_in_100mhz),
    .rst           (clr),
    .run           (locked),
    .clk_div       (clk_div10),
    .en_div        (en_div10)
  );

endmodule

// File: tb/tb_cmu_clkgen.sv
// tb_cmu_clkgen
//   Bench for cmu_clkgen. Two instances share the stimulus: one with the
//   default 32-bit cycle counter, one with a 4-bit counter for wrap checks.
//   Each cycle the expected outputs are computed in closed form from the
//   number of clean edges since the last reset and queued as the input is
//   driven; they are popped and compared once the edge has happened.
module tb_cmu_clkgen;

  localparam int L = 64;
  localparam int S = 128;

  // Clock / reset block
  logic clk_in_100mhz = 1'b0;
  logic rst           = 1'b1;
  logic pwrdwn        = 1'b0;

  always #5 clk_in_100mhz = ~clk_in_100mhz;

  logic        locked, stable, rst_out;
  logic        clk_div2, clk_div4, clk_div10;
  logic        en_div2, en_div4, en_div10;
  logic [31:0] cycle_count;

  logic        w4_locked, w4_stable, w4_rst_out;
  logic        w4_clk_div2, w4_clk_div4, w4_clk_div10;
  logic        w4_en_div2, w4_en_div4, w4_en_div10;
  logic [3:0]  w4_cycle_count;

  cmu_clkgen #(.LOCK_CYCLES(L), .STABLE_COUNT(S), .COUNT_WIDTH(32)) dut (
    .clk_in_100mhz (clk_in_100mhz),
    .rst           (rst),
    .pwrdwn        (pwrdwn),
    .locked        (locked),
    .stable        (stable),
    .rst_out       (rst_out),
    .clk_div2      (clk_div2),
    .clk_div4      (clk_div4),
    .clk_div10     (clk_div10),
    .en_div2       (en_div2),
    .en_div4       (en_div4),
    .en_div10      (en_div10),
    .cycle_count   (cycle_count)
  );

  cmu_clkgen #(.LOCK_CYCLES(L), .STABLE_COUNT(S), .COUNT_WIDTH(4)) dut_w4 (
    .clk_in_100mhz (clk_in_100mhz),
    .rst           (rst),
    .pwrdwn        (pwrdwn),
    .locked        (w4_locked),
    .stable        (w4_stable),
    .rst_out       (w4_rst_out),
    .clk_div2      (w4_clk_div2),
    .clk_div4      (w4_clk_div4),
    .clk_div10     (w4_clk_div10),
    .en_div2       (w4_en_div2),
    .en_div4       (w4_en_div4),
    .en_div10      (w4_en_div10),
    .cycle_count   (w4_cycle_count)
  );

  // Scoreboard
  logic [40:0] exp_q[$];
  logic [12:0] exp_w4_q[$];
  int          n_run = 0;
  int          total = 0;
  int          bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected {locked,stable,rst_out,div2,div4,div10,en2,en4,en10,count}
  // after n clean edges since reset.
  function automatic logic [40:0] model_vec(input int n);
    logic        lk, st;
    int          t;
    logic [31:0] cc;
    lk = (n >= L);
    st = (n >= L + S);
    t  = n - L;
    cc = st ? 32'(n - (L + S)) : 32'd0;
    return {lk, st, !st,
            lk && ((t % 2) < 1), lk && ((t % 4) < 2), lk && ((t % 10) < 5),
            lk && ((t % 2) == 0), lk && ((t % 4) == 0), lk && ((t % 10) == 0),
            cc};
  endfunction

  function automatic logic [40:0] dut_vec();
    return {locked, stable, rst_out, clk_div2, clk_div4, clk_div10,
            en_div2, en_div4, en_div10, cycle_count};
  endfunction

  function automatic logic [12:0] w4_vec();
    return {w4_locked, w4_stable, w4_rst_out, w4_clk_div2, w4_clk_div4,
            w4_clk_div10, w4_en_div2, w4_en_div4, w4_en_div10, w4_cycle_count};
  endfunction

  // Driver: called at a falling edge; drives inputs, queues the expected
  // outputs for after the next rising edge, then compares at the next
  // falling edge.
  task automatic step(input logic r, input logic p);
    logic [40:0] e;
    logic [12:0] e4;
    rst    = r;
    pwrdwn = p;
    if (r || p) n_run = 0;
    else        n_run++;
    e = model_vec(n_run);
    exp_q.push_back(e);
    exp_w4_q.push_back({e[40:32], e[3:0]});
    @(posedge clk_in_100mhz);
    @(negedge clk_in_100mhz);
    check_eq("stream", 64'(dut_vec()), 64'(exp_q.pop_front()));
    check_eq("stream_w4", 64'(w4_vec()), 64'(exp_w4_q.pop_front()));
  endtask

  task automatic check_all_reset(input string tag);
    check_eq({tag, "_locked"},  64'(locked),  64'd0);
    check_eq({tag, "_stable"},  64'(stable),  64'd0);
    check_eq({tag, "_rst_out"}, 64'(rst_out), 64'd1);
    check_eq({tag, "_clk"},     64'({clk_div2, clk_div4, clk_div10}), 64'd0);
    check_eq({tag, "_en"},      64'({en_div2, en_div4, en_div10}),    64'd0);
    check_eq({tag, "_count"},   64'(cycle_count), 64'd0);
  endtask

  logic [39:0] d2, d4, d10, x2, x4, x10;
  int          pulse_idx[$];

  initial begin
    @(negedge clk_in_100mhz);

    // Reset held for 5 cycles.
    repeat (5) step(1'b1, 1'b0);
    check_all_reset("reset");

    // Lock: not yet after edge 63, locked after edge 64 with phases at 0.
    repeat (L - 1) step(1'b0, 1'b0);
    check_eq("prelock_locked", 64'(locked), 64'd0);
    step(1'b0, 1'b0);
    check_eq("lock_locked", 64'(locked), 64'd1);
    check_eq("lock_clk", 64'({clk_div2, clk_div4, clk_div10}), 64'h7);
    check_eq("lock_en",  64'({en_div2, en_div4, en_div10}),    64'h7);

    // Divider waveforms over 40 locked cycles (index 0 = first locked cycle).
    for (int i = 0; i < 40; i++) begin
      if (i != 0) step(1'b0, 1'b0);
      d2[i]  = clk_div2;
      d4[i]  = clk_div4;
      d10[i] = clk_div10;
      x2[i]  = ((i % 2) == 0);
      x4[i]  = ((i % 4) < 2);
      x10[i] = ((i % 10) < 5);
      if (en_div10) pulse_idx.push_back(i);
    end
    check_eq("wave_div2",  64'(d2),  64'(x2));
    check_eq("wave_div4",  64'(d4),  64'(x4));
    check_eq("wave_div10", 64'(d10), 64'(x10));
    check_eq("en10_pulses", 64'(pulse_idx.size()), 64'd4);
    if (pulse_idx.size() > 0) check_eq("en10_first", 64'(pulse_idx[0]), 64'd0);
    for (int k = 1; k < pulse_idx.size(); k++)
      check_eq("en10_gap", 64'(pulse_idx[k] - pulse_idx[k-1]), 64'd10);

    // Stable after edge 192 (now at edge 103).
    repeat (L + S - 1 - n_run) step(1'b0, 1'b0);
    check_eq("prestable_stable", 64'(stable), 64'd0);
    step(1'b0, 1'b0);
    check_eq("stable_stable",  64'(stable),      64'd1);
    check_eq("stable_rst_out", 64'(rst_out),     64'd0);
    check_eq("stable_count0",  64'(cycle_count), 64'd0);
    repeat (10) step(1'b0, 1'b0);
    check_eq("count_10", 64'(cycle_count), 64'd10);

    // 4-bit counter wrap: 15 -> 0 -> ... -> 3.
    repeat (5) step(1'b0, 1'b0);
    check_eq("w4_count15", 64'(w4_cycle_count), 64'd15);
    step(1'b0, 1'b0);
    check_eq("w4_wrap0", 64'(w4_cycle_count), 64'd0);
    check_eq("count_16", 64'(cycle_count), 64'd16);
    repeat (3) step(1'b0, 1'b0);
    check_eq("w4_count3", 64'(w4_cycle_count), 64'd3);

    // Advance to clk_div10 phase 3, then a one-cycle power-down pulse.
    while (((n_run - L) % 10) != 3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check_all_reset("pwrdwn");

    // Relock after 64 further clean edges, phases restarting at 0.
    repeat (L - 1) step(1'b0, 1'b0);
    check_eq("relock_pre", 64'(locked), 64'd0);
    step(1'b0, 1'b0);
    check_eq("relock_locked", 64'(locked), 64'd1);
    check_eq("relock_clk", 64'({clk_div2, clk_div4, clk_div10}), 64'h7);
    check_eq("relock_en",  64'({en_div2, en_div4, en_div10}),    64'h7);
    repeat (12) step(1'b0, 1'b0);

    // Reset mid-period also clears everything.
    step(1'b1, 1'b0);
    check_all_reset("rst_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the sequence is fixed-length, this only guards against a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
